// File: rtl/vector_beat_packer_pkg.sv
// Shared constants, state encoding and configuration helper for the vector beat packer.
package vector_beat_packer_pkg;

  // Beat geometry shared with the downstream MAC: 16 lanes of 8 bits.
  localparam int VB_BUSW      = 128;
  localparam int VB_LANE_W    = 8;
  localparam int VB_MAX_LANES = 16;

  // FILL accepts elements; GAP is the single idle cycle between vectors (also the reset state).
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_GAP  = 1'b1
  } vbp_state_e;

  // Lane counts the MAC datapath supports.
  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/vector_beat_packer.sv
// Packs a stream of INT8 (a,b) pairs into 128-bit beats for the vector MAC.
// The final partial beat of a vector is zero-padded and vectors are separated
// by at least one idle cycle. The MAC cannot stall, so every beat is a single
// one-cycle pulse on vec_valid.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | in_ready=1, elements are written into the assembly register
// GAP   | in_ready=0 for one cycle after a vector's last element; reset state
module vector_beat_packer
  import vector_beat_packer_pkg::*;
#(
  parameter int ELEMS        = 1000,
  parameter int ACTIVE_LANES = 8,
  parameter int BUSW         = VB_BUSW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_a,
  input  logic [7:0]      in_b,
  input  logic            in_last,
  output logic            vec_valid,
  output logic [BUSW-1:0] vec_a,
  output logic [BUSW-1:0] vec_b,
  output logic            len_err,
  output logic [31:0]     vec_done_cnt
);

  localparam int EW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int LW = (ACTIVE_LANES > 1) ? $clog2(ACTIVE_LANES) : 1;
  localparam logic [EW-1:0] ELEM_MAX = EW'(ELEMS - 1);
  localparam logic [LW-1:0] LANE_MAX = LW'(ACTIVE_LANES - 1);

  if (!lanes_legal(ACTIVE_LANES) || (ELEMS < 1) || (BUSW != VB_LANE_W * VB_MAX_LANES)) begin : g_bad_cfg
    $error("vector_beat_packer: ACTIVE_LANES must be 1, 4, 8 or 16, ELEMS >= 1, BUSW = 128");
  end

  vbp_state_e      state_q, state_d;
  logic [EW-1:0]   elem_idx_q, elem_idx_d;
  logic [LW-1:0]   lane_idx_q, lane_idx_d;
  logic [BUSW-1:0] asm_a_q, asm_a_d, asm_b_q, asm_b_d;
  logic [BUSW-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [BUSW-1:0] fill_a, fill_b;
  logic            vld_q, vld_d;
  logic            len_err_q, len_err_d;
  logic [31:0]     done_cnt_q, done_cnt_d;
  logic            xfer;
  logic            elem_last;
  logic            lane_full;

  assign xfer      = in_valid & in_ready;
  assign elem_last = (elem_idx_q == ELEM_MAX);
  assign lane_full = (lane_idx_q == LANE_MAX);

  // State register; reset lands in GAP so in_ready rises one clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_GAP;
    else        state_q <= state_d;
  end

  // Next-state and handshake: leave FILL on the vector's final element, GAP lasts one cycle.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_FILL: begin
        in_ready = 1'b1;
        if (xfer && elem_last) state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_FILL;
      default: state_d = ST_GAP;
    endcase
  end

  // Datapath next values: lane write, beat hand-off, counters and length check.
  always_comb begin
    elem_idx_d = elem_idx_q;
    lane_idx_d = lane_idx_q;
    asm_a_d    = asm_a_q;
    asm_b_d    = asm_b_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    vld_d      = 1'b0;
    len_err_d  = len_err_q;
    done_cnt_d = done_cnt_q;
    fill_a     = asm_a_q;
    fill_b     = asm_b_q;
    fill_a[int'(lane_idx_q) * VB_LANE_W +: VB_LANE_W] = in_a;
    fill_b[int'(lane_idx_q) * VB_LANE_W +: VB_LANE_W] = in_b;
    if (xfer) begin
      // in_last is only checked, the ELEMS count alone decides where a vector ends.
      if (in_last != elem_last) len_err_d = 1'b1;
      if (lane_full || elem_last) begin
        // Completed beat moves to the output register; assembly restarts from zero
        // so unfilled lanes of a short final beat read as zero.
        out_a_d    = fill_a;
        out_b_d    = fill_b;
        vld_d      = 1'b1;
        asm_a_d    = '0;
        asm_b_d    = '0;
        lane_idx_d = '0;
      end else begin
        asm_a_d    = fill_a;
        asm_b_d    = fill_b;
        lane_idx_d = lane_idx_q + LW'(1);
      end
      if (elem_last) begin
        elem_idx_d = '0;
        done_cnt_d = done_cnt_q + 32'd1;
      end else begin
        elem_idx_d = elem_idx_q + EW'(1);
      end
    end
  end

  // Datapath registers; a partially assembled beat is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_idx_q <= '0;
      lane_idx_q <= '0;
      asm_a_q    <= '0;
      asm_b_q    <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      vld_q      <= 1'b0;
      len_err_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      elem_idx_q <= elem_idx_d;
      lane_idx_q <= lane_idx_d;
      asm_a_q    <= asm_a_d;
      asm_b_q    <= asm_b_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      vld_q      <= vld_d;
      len_err_q  <= len_err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign vec_valid    = vld_q;
  assign vec_a        = out_a_q;
  assign vec_b        = out_b_q;
  assign len_err      = len_err_q;
  assign vec_done_cnt = done_cnt_q;

endmodule
